// File: rtl/fdc_pkg.sv
// Shared constants for the FDC code averager slice.
//   CODE_W_DEF : default FDC code width
//   LOG2_N_DEF : default log2 of samples per averaging window
//   ACC_W      : accumulator width for the defaults (sum of N max codes fits)
//   CODE_MAX   : all-ones code, the reset value of the running window minimum
package fdc_pkg;

  localparam int unsigned CODE_W_DEF = 5;
  localparam int unsigned LOG2_N_DEF = 4;
  localparam int unsigned ACC_W      = CODE_W_DEF + LOG2_N_DEF;
  localparam logic [CODE_W_DEF-1:0] CODE_MAX = '1;

endpackage

// File: rtl/fdc_ref_sync.sv
// Resynchronises the raw reference pin into clk and emits a one-cycle tick
// per rising edge.
//   clk    : system clock
//   rst_n  : async active-low reset
//   ref_in : raw reference pin, asynchronous to clk
//   tick   : one clk cycle high per synchronised rising edge of ref_in
module fdc_ref_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ref_in,
  output logic tick
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   edge_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      edge_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], ref_in};
      edge_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign tick = sync_q[SYNC_STAGES-1] & ~edge_q;

endmodule

// File: rtl/fdc_code_averager.sv
// Windowed statistics over the FDC code output. One code is sampled per
// synchronised rising edge of ref_in; every 2^LOG2_N samples the truncated
// mean, minimum and maximum are loaded into a valid/ready output register.
//   clk, rst_n  : system clock, async active-low reset
//   ref_in      : raw reference pin (sampling strobe)
//   code_in     : FDC code, stable when the sample is taken
//   en          : 1 = accumulate, 0 = hold window in its reset state
//   out_ready   : consumer accepts the held result
//   clr_ovr     : clears the sticky overrun flag
//   avg_out/min_out/max_out : last window result
//   out_valid   : result register holds an unconsumed result
//   overrun     : sticky, an unconsumed result was overwritten
//   sample_cnt  : samples taken in the current window
module fdc_code_averager
  import fdc_pkg::*;
#(
  parameter int unsigned CODE_W      = CODE_W_DEF,
  parameter int unsigned LOG2_N      = LOG2_N_DEF,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ref_in,
  input  logic [CODE_W-1:0] code_in,
  input  logic              en,
  input  logic              out_ready,
  input  logic              clr_ovr,
  output logic [CODE_W-1:0] avg_out,
  output logic [CODE_W-1:0] min_out,
  output logic [CODE_W-1:0] max_out,
  output logic              out_valid,
  output logic              overrun,
  output logic [LOG2_N-1:0] sample_cnt
);

  localparam int unsigned ACC_WL = CODE_W + LOG2_N;

  logic              tick;
  logic [ACC_WL-1:0] acc_q, acc_d, sum;
  logic [LOG2_N-1:0] cnt_q, cnt_d;
  logic [CODE_W-1:0] win_min_q, win_min_d, win_max_q, win_max_d;
  logic [CODE_W-1:0] min_new, max_new;
  logic [CODE_W-1:0] avg_q, avg_d, min_q, min_d, max_q, max_d;
  logic              valid_q, valid_d, ovr_q, ovr_d;
  logic              sample, close;

  fdc_ref_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .ref_in (ref_in),
    .tick   (tick)
  );

  always_comb begin
    sample  = tick & en;
    close   = sample & (&cnt_q);
    sum     = acc_q + ACC_WL'(code_in);
    min_new = (code_in < win_min_q) ? code_in : win_min_q;
    max_new = (code_in > win_max_q) ? code_in : win_max_q;

    acc_d     = acc_q;
    cnt_d     = cnt_q;
    win_min_d = win_min_q;
    win_max_d = win_max_q;
    avg_d     = avg_q;
    min_d     = min_q;
    max_d     = max_q;
    valid_d   = valid_q;
    ovr_d     = ovr_q;

    if (!en) begin
      acc_d     = '0;
      cnt_d     = '0;
      win_min_d = '1;
      win_max_d = '0;
    end else if (close) begin
      acc_d     = '0;
      cnt_d     = '0;
      win_min_d = '1;
      win_max_d = '0;
    end else if (sample) begin
      acc_d     = sum;
      cnt_d     = cnt_q + 1'b1;
      win_min_d = min_new;
      win_max_d = max_new;
    end

    // The closing sample is folded in on the same edge, so the result
    // registers take the combinational sum/min/max rather than the window regs.
    if (close) begin
      avg_d   = sum[ACC_WL-1:LOG2_N];
      min_d   = min_new;
      max_d   = max_new;
      valid_d = 1'b1;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end

    // A set on the same edge as clr_ovr takes priority.
    if (close && valid_q && !out_ready) begin
      ovr_d = 1'b1;
    end else if (clr_ovr) begin
      ovr_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q     <= '0;
      cnt_q     <= '0;
      win_min_q <= '1;
      win_max_q <= '0;
      avg_q     <= '0;
      min_q     <= '0;
      max_q     <= '0;
      valid_q   <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      win_min_q <= win_min_d;
      win_max_q <= win_max_d;
      avg_q     <= avg_d;
      min_q     <= min_d;
      max_q     <= max_d;
      valid_q   <= valid_d;
      ovr_q     <= ovr_d;
    end
  end

  assign avg_out    = avg_q;
  assign min_out    = min_q;
  assign max_out    = max_q;
  assign out_valid  = valid_q;
  assign overrun    = ovr_q;
  assign sample_cnt = cnt_q;

endmodule

// File: tb/tb_fdc_code_averager.sv
module tb_fdc_code_averager;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ref_in = 1'b0;
  logic [4:0] code_in = '0;
  logic       en = 1'b0;
  logic       out_ready = 1'b0;
  logic       clr_ovr = 1'b0;
  logic [4:0] avg_out, min_out, max_out;
  logic       out_valid, overrun;
  logic [3:0] sample_cnt;

  int errors = 0;
  int checks = 0;
  int vcnt = 0;

  fdc_code_averager #(
    .CODE_W      (5),
    .LOG2_N      (4),
    .SYNC_STAGES (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ref_in     (ref_in),
    .code_in    (code_in),
    .en         (en),
    .out_ready  (out_ready),
    .clr_ovr    (clr_ovr),
    .avg_out    (avg_out),
    .min_out    (min_out),
    .max_out    (max_out),
    .out_valid  (out_valid),
    .overrun    (overrun),
    .sample_cnt (sample_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (out_valid === 1'b1) vcnt++;

  typedef struct {
    int code0;
    int step;
    int exp_avg;
    int exp_min;
    int exp_max;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One ref_in pulse: high for 3 edges, low for 3. The sample edge is the
  // third high edge; clr_ovr / out_ready can be forced on exactly that edge.
  task automatic pulse(input int code, input bit clr, input bit rdy);
    logic save_rdy;
    @(negedge clk);
    code_in = 5'(code);
    ref_in  = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    save_rdy = out_ready;
    clr_ovr  = clr;
    if (rdy) out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clr_ovr   = 1'b0;
    out_ready = save_rdy;
    ref_in    = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  task automatic run_window(input int code0, input int step, input bit clr, input bit rdy);
    for (int i = 0; i < 16; i++)
      pulse(code0 + i * step, (i == 15) ? clr : 1'b0, (i == 15) ? rdy : 1'b0);
  endtask

  task automatic consume();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic check_result(input string tag, input int a, input int mn, input int mx);
    @(negedge clk);
    chk({tag, "_avg"}, 32'(avg_out), a);
    chk({tag, "_min"}, 32'(min_out), mn);
    chk({tag, "_max"}, 32'(max_out), mx);
  endtask

  initial begin
    int v0;
    vecs[0] = '{10, 0, 10, 10, 10};
    vecs[1] = '{0, 1, 7, 0, 15};
    vecs[2] = '{31, 0, 31, 31, 31};
    vecs[3] = '{31, 31, 23, 16, 31};
    vecs[4] = '{0, 2, 15, 0, 30};
    vecs[5] = '{5, 16, 13, 5, 21};

    // Reset state
    #3;
    chk("rst_avg", 32'(avg_out), 0);
    chk("rst_min", 32'(min_out), 0);
    chk("rst_max", 32'(max_out), 0);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_ovr", 32'(overrun), 0);
    chk("rst_cnt", 32'(sample_cnt), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    en    = 1'b1;

    // Table-driven windows
    foreach (vecs[k]) begin
      run_window(vecs[k].code0, vecs[k].step, 1'b0, 1'b0);
      check_result("tbl", vecs[k].exp_avg, vecs[k].exp_min, vecs[k].exp_max);
      chk("tbl_valid", 32'(out_valid), 1);
      chk("tbl_cnt", 32'(sample_cnt), 0);
      chk("tbl_ovr", 32'(overrun), 0);
      consume();
      chk("tbl_consumed", 32'(out_valid), 0);
    end

    // Overwrite and overrun handling
    run_window(3, 0, 1'b0, 1'b0);
    check_result("ow1", 3, 3, 3);
    chk("ow1_ovr", 32'(overrun), 0);
    run_window(20, 0, 1'b0, 1'b0);
    check_result("ow2", 20, 20, 20);
    chk("ow2_ovr", 32'(overrun), 1);
    chk("ow2_valid", 32'(out_valid), 1);
    @(negedge clk); clr_ovr = 1'b1;
    @(negedge clk); clr_ovr = 1'b0;
    chk("clr_ovr", 32'(overrun), 0);
    chk("clr_valid", 32'(out_valid), 1);
    run_window(7, 0, 1'b1, 1'b0);
    check_result("setwins", 7, 7, 7);
    chk("setwins_ovr", 32'(overrun), 1);

    // Cleanup
    @(negedge clk); clr_ovr = 1'b1;
    @(negedge clk); clr_ovr = 1'b0;
    consume();
    chk("pre4_valid", 32'(out_valid), 0);

    // out_ready held high: valid lasts exactly one cycle
    out_ready = 1'b1;
    v0 = vcnt;
    run_window(6, 0, 1'b0, 1'b0);
    @(negedge clk);
    chk("rdy_vcycles", 32'(vcnt - v0), 1);
    chk("rdy_valid", 32'(out_valid), 0);
    chk("rdy_avg", 32'(avg_out), 6);
    out_ready = 1'b0;

    // Ready on the close edge of the next window: valid stays, no overrun
    run_window(4, 0, 1'b0, 1'b0);
    check_result("hs1", 4, 4, 4);
    run_window(9, 0, 1'b0, 1'b1);
    check_result("hs2", 9, 9, 9);
    chk("hs2_valid", 32'(out_valid), 1);
    chk("hs2_ovr", 32'(overrun), 0);
    consume();

    // en=0 mid-window discards the partial window
    for (int i = 0; i < 5; i++) pulse(1, 1'b0, 1'b0);
    @(negedge clk);
    chk("en_cnt5", 32'(sample_cnt), 5);
    en = 1'b0;
    @(negedge clk);
    chk("en0_cnt", 32'(sample_cnt), 0);
    repeat (2) @(negedge clk);
    en = 1'b1;
    for (int i = 0; i < 15; i++) pulse(31, 1'b0, 1'b0);
    @(negedge clk);
    chk("en_15_valid", 32'(out_valid), 0);
    chk("en_15_cnt", 32'(sample_cnt), 15);
    pulse(31, 1'b0, 1'b0);
    check_result("en16", 31, 31, 31);
    chk("en16_valid", 32'(out_valid), 1);

    // Reset mid-window with a held result
    for (int i = 0; i < 9; i++) pulse(2, 1'b0, 1'b0);
    @(negedge clk);
    chk("mr_cnt9", 32'(sample_cnt), 9);
    chk("mr_valid", 32'(out_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_avg", 32'(avg_out), 0);
    chk("mr_min", 32'(min_out), 0);
    chk("mr_max", 32'(max_out), 0);
    chk("mr_valid0", 32'(out_valid), 0);
    chk("mr_cnt0", 32'(sample_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 15; i++) pulse(12, 1'b0, 1'b0);
    @(negedge clk);
    chk("mr_15_valid", 32'(out_valid), 0);
    pulse(12, 1'b0, 1'b0);
    check_result("mr16", 12, 12, 12);
    chk("mr16_valid", 32'(out_valid), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
